// File: rtl/data_array_refill_writer_pkg.sv
// rtl/data_array_refill_writer_pkg.sv - shared widths and refill state encoding for the data-array refill writer
package data_array_refill_writer_pkg;

  localparam int ADDR_WIDTH     = 8;
  localparam int WORD_WIDTH     = 20;
  localparam int NUM_BLOCKS     = 4;
  localparam int WORDS_PER_LINE = 4;

  localparam int OFFSET_WIDTH = $clog2(WORDS_PER_LINE);
  localparam int SET_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int CNT_WIDTH    = OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } refill_state_e;

endpackage

// File: rtl/data_array_refill_writer_if.sv
// rtl/data_array_refill_writer_if.sv - refill command, fill stream and data-array write port bundle
interface data_array_refill_writer_if;
  import data_array_refill_writer_pkg::*;

  logic                    i_req_valid;
  logic [SET_WIDTH-1:0]    i_req_set;
  logic [NUM_BLOCKS-1:0]   i_req_way;
  logic [OFFSET_WIDTH-1:0] i_req_first_word;
  logic                    o_req_ready;

  logic [WORD_WIDTH-1:0]   i_fill_data;
  logic                    i_fill_valid;
  logic                    o_fill_ready;

  logic [ADDR_WIDTH-1:0]   o_w_addr;
  logic [WORD_WIDTH-1:0]   o_w_data;
  logic                    o_w_valid;
  logic [NUM_BLOCKS-1:0]   o_w_mask;
  logic                    i_w_ready;

  logic                    o_stop_write_clk;
  logic                    o_busy;
  logic                    o_done;

  modport slave (
    input  i_req_valid, i_req_set, i_req_way, i_req_first_word,
    input  i_fill_data, i_fill_valid, i_w_ready,
    output o_req_ready, o_fill_ready,
    output o_w_addr, o_w_data, o_w_valid, o_w_mask,
    output o_stop_write_clk, o_busy, o_done
  );

  modport master (
    output i_req_valid, i_req_set, i_req_way, i_req_first_word,
    output i_fill_data, i_fill_valid, i_w_ready,
    input  o_req_ready, o_fill_ready,
    input  o_w_addr, o_w_data, o_w_valid, o_w_mask,
    input  o_stop_write_clk, o_busy, o_done
  );

endinterface

// File: rtl/data_array_refill_writer_offset_counter.sv
// rtl/data_array_refill_writer_offset_counter.sv - wrapping line offset plus accepted-word count
module refill_offset_counter
  import data_array_refill_writer_pkg::*;
(
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    i_halt,
  input  logic                    i_load,
  input  logic [OFFSET_WIDTH-1:0] i_load_offset,
  input  logic                    i_inc,
  output logic [OFFSET_WIDTH-1:0] o_offset,
  output logic [CNT_WIDTH-1:0]    o_count
);

  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;

  // Load restarts the line at the start offset; increment wraps within the line by truncation.
  always_comb begin
    offset_d = offset_q;
    count_d  = count_q;
    if (!i_halt) begin
      if (i_load) begin
        offset_d = i_load_offset;
        count_d  = '0;
      end else if (i_inc) begin
        offset_d = offset_q + OFFSET_WIDTH'(1);
        count_d  = count_q + CNT_WIDTH'(1);
      end
    end
  end

  // Offset and count registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      offset_q <= '0;
      count_q  <= '0;
    end else begin
      offset_q <= offset_d;
      count_q  <= count_d;
    end
  end

  assign o_offset = offset_q;
  assign o_count  = count_q;

endmodule

// File: rtl/data_array_refill_writer.sv
// rtl/data_array_refill_writer.sv - refill line writer for icache data arrays; REFILL_WRAP_FIRST_EN enables critical-word-first
module data_array_refill_writer
  import data_array_refill_writer_pkg::*;
(
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        i_halt_all,
  data_array_refill_writer_if.slave   bus
);

  refill_state_e           state_q, state_d;
  logic [SET_WIDTH-1:0]    set_q, set_d;
  logic [NUM_BLOCKS-1:0]   way_q, way_d;
  logic [CNT_WIDTH-1:0]    written_q, written_d;
  logic                    w_valid_q, w_valid_d;
  logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
  logic [WORD_WIDTH-1:0]   w_data_q, w_data_d;
  logic [NUM_BLOCKS-1:0]   w_mask_q, w_mask_d;

  logic                    req_ready, fill_ready, busy, done, stop_clk;
  logic                    req_fire, fill_fire, retire, last_retire;
  logic [OFFSET_WIDTH-1:0] offset, start_offset;
  logic [CNT_WIDTH-1:0]    accepted;

`ifdef REFILL_WRAP_FIRST_EN
  assign start_offset = bus.i_req_first_word;
`else
  logic unused_first_word;
  assign start_offset      = '0;
  assign unused_first_word = ^bus.i_req_first_word;
`endif

  assign req_fire    = bus.i_req_valid & req_ready;
  assign fill_fire   = bus.i_fill_valid & fill_ready;
  // A halted cycle never retires a beat, even with the arrays ready.
  assign retire      = ~i_halt_all & w_valid_q & bus.i_w_ready;
  assign last_retire = retire & (written_q == CNT_WIDTH'(WORDS_PER_LINE - 1));

  refill_offset_counter u_offset (
    .clk          (clk),
    .srst         (srst),
    .i_halt       (i_halt_all),
    .i_load       (req_fire),
    .i_load_offset(start_offset),
    .i_inc        (fill_fire),
    .o_offset     (offset),
    .o_count      (accepted)
  );

  // State register and write-beat registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      set_q     <= '0;
      way_q     <= '0;
      written_q <= '0;
      w_valid_q <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_mask_q  <= '0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      way_q     <= way_d;
      written_q <= written_d;
      w_valid_q <= w_valid_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_mask_q  <= w_mask_d;
    end
  end

  // Next state: FILL ends only when the final beat retires with nothing new accepted.
  always_comb begin
    state_d = state_q;
    if (!i_halt_all) begin
      case (state_q)
        ST_IDLE: if (req_fire) state_d = ST_FILL;
        ST_FILL: if (last_retire && !fill_fire) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register and the write-beat slot.
  always_comb begin
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    stop_clk   = 1'b1;
    case (state_q)
      ST_IDLE: req_ready = ~i_halt_all;
      ST_FILL: begin
        fill_ready = ~i_halt_all & (accepted < CNT_WIDTH'(WORDS_PER_LINE))
                   & (~w_valid_q | bus.i_w_ready);
        busy       = 1'b1;
        stop_clk   = 1'b0;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Command capture, retire counting and beat loading; a same-cycle accept overrides the retire clear.
  always_comb begin
    set_d     = set_q;
    way_d     = way_q;
    written_d = written_q;
    w_valid_d = w_valid_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_mask_d  = w_mask_q;
    if (req_fire) begin
      set_d     = bus.i_req_set;
      way_d     = bus.i_req_way;
      written_d = '0;
    end
    if (retire) begin
      written_d = written_q + CNT_WIDTH'(1);
      w_valid_d = 1'b0;
    end
    if (fill_fire) begin
      w_valid_d = 1'b1;
      w_addr_d  = {set_q, offset};
      w_data_d  = bus.i_fill_data;
      w_mask_d  = way_q;
    end
  end

  assign bus.o_req_ready      = req_ready;
  assign bus.o_fill_ready     = fill_ready;
  assign bus.o_w_valid        = w_valid_q;
  assign bus.o_w_addr         = w_addr_q;
  assign bus.o_w_data         = w_data_q;
  assign bus.o_w_mask         = w_mask_q;
  assign bus.o_stop_write_clk = stop_clk;
  assign bus.o_busy           = busy;
  assign bus.o_done           = done;

endmodule

// File: tb/tb_data_array_refill_writer.sv
// tb/tb_data_array_refill_writer.sv - directed vector bench for data_array_refill_writer
module tb_data_array_refill_writer;
  import data_array_refill_writer_pkg::*;

  logic clk = 1'b0;
  logic srst;
  logic halt;

  data_array_refill_writer_if bus ();

  data_array_refill_writer dut (
    .clk       (clk),
    .srst      (srst),
    .i_halt_all(halt),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         rv;
    logic [5:0] set;
    logic [3:0] way;
    logic [1:0] first;
    bit         fv;
    logic [19:0] fd;
    bit         wr;
    bit         e_rr;
    bit         e_fr;
    bit         e_wv;
    logic [7:0] e_addr;
    logic [19:0] e_data;
    logic [3:0] e_mask;
    bit         e_done;
    bit         e_busy;
    bit         e_stop;
  } vec_t;

  vec_t tbl[$];

`ifdef REFILL_WRAP_FIRST_EN
  localparam logic [7:0] WA0 = 8'hFE, WA1 = 8'hFF, WA2 = 8'hFC, WA3 = 8'hFD;
`else
  localparam logic [7:0] WA0 = 8'hFC, WA1 = 8'hFD, WA2 = 8'hFE, WA3 = 8'hFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int rv, input int set, input int way, input int first,
                        input int fv, input int fd, input int wr, input int h, input int rst);
    bus.i_req_valid      = 1'(rv);
    bus.i_req_set        = 6'(set);
    bus.i_req_way        = 4'(way);
    bus.i_req_first_word = 2'(first);
    bus.i_fill_valid     = 1'(fv);
    bus.i_fill_data      = 20'(fd);
    bus.i_w_ready        = 1'(wr);
    halt                 = 1'(h);
    srst                 = 1'(rst);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    set_in(int'(v.rv), int'(v.set), int'(v.way), int'(v.first),
           int'(v.fv), int'(v.fd), int'(v.wr), 0, 0);
    @(negedge clk);
    chk($sformatf("row%0d_req_ready", idx), 32'(bus.o_req_ready), 32'(v.e_rr));
    chk($sformatf("row%0d_fill_ready", idx), 32'(bus.o_fill_ready), 32'(v.e_fr));
    chk($sformatf("row%0d_w_valid", idx), 32'(bus.o_w_valid), 32'(v.e_wv));
    if (v.e_wv) begin
      chk($sformatf("row%0d_w_addr", idx), 32'(bus.o_w_addr), 32'(v.e_addr));
      chk($sformatf("row%0d_w_data", idx), 32'(bus.o_w_data), 32'(v.e_data));
      chk($sformatf("row%0d_w_mask", idx), 32'(bus.o_w_mask), 32'(v.e_mask));
    end
    chk($sformatf("row%0d_done", idx), 32'(bus.o_done), 32'(v.e_done));
    chk($sformatf("row%0d_busy", idx), 32'(bus.o_busy), 32'(v.e_busy));
    chk($sformatf("row%0d_stop_clk", idx), 32'(bus.o_stop_write_clk), 32'(v.e_stop));
    tick();
  endtask

  task automatic chk_beat(input string name, input int addr, input int data);
    @(negedge clk);
    chk({name, "_w_valid"}, 32'(bus.o_w_valid), 32'd1);
    chk({name, "_w_addr"}, 32'(bus.o_w_addr), 32'(addr));
    chk({name, "_w_data"}, 32'(bus.o_w_data), 32'(data));
  endtask

  initial begin
    // clean fill, done pulse and request offered in DONE
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 6'h05, 4'h2, 2'd0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hA0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hA0001, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 20'hA0000, 4'h2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hA0002, 1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 20'hA0001, 4'h2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hA0003, 1'b1, 1'b0, 1'b1, 1'b1, 8'h16, 20'hA0002, 4'h2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b1, 8'h17, 20'hA0003, 4'h2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 6'h3F, 4'h8, 2'd2, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b1, 1'b1, 1'b1});
    // wrap fill accepted once back in IDLE
    tbl.push_back('{1'b1, 6'h3F, 4'h8, 2'd2, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hB0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hB0001, 1'b1, 1'b0, 1'b1, 1'b1, WA0,   20'hB0000, 4'h8, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hB0002, 1'b1, 1'b0, 1'b1, 1'b1, WA1,   20'hB0001, 4'h8, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hB0003, 1'b1, 1'b0, 1'b1, 1'b1, WA2,   20'hB0002, 4'h8, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b1, WA3,   20'hB0003, 4'h8, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});
    // backpressure: write port stalls three cycles on the second beat
    tbl.push_back('{1'b1, 6'h01, 4'h1, 2'd0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0001, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 20'hC0000, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0002, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 20'hC0001, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0002, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 20'hC0001, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0002, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 20'hC0001, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0002, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 20'hC0001, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b1, 20'hC0003, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 20'hC0002, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 20'hC0003, 4'h1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 6'h00, 4'h0, 2'd0, 1'b0, 20'h0,     1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 20'h0,     4'h0, 1'b0, 1'b0, 1'b1});

    // reset state
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_w_valid", 32'(bus.o_w_valid), 32'd0);
    chk("rst_w_addr", 32'(bus.o_w_addr), 32'd0);
    chk("rst_w_data", 32'(bus.o_w_data), 32'd0);
    chk("rst_w_mask", 32'(bus.o_w_mask), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_stop_clk", 32'(bus.o_stop_write_clk), 32'd1);
    tick();

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // halt for four cycles mid-fill with fill data offered
    set_in(1, 'h02, 'h4, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("halt_req_ready", 32'(bus.o_req_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 1, 'hD0000, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 'hD0001, 1, 0, 0);
    chk_beat("halt_pre", 'h08, 'hD0000);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 'h10, 'h1, 0, 1, 'hD0002, 1, 1, 0);
      chk_beat($sformatf("halt%0d", k), 'h09, 'hD0001);
      chk($sformatf("halt%0d_fill_ready", k), 32'(bus.o_fill_ready), 32'd0);
      chk($sformatf("halt%0d_req_ready", k), 32'(bus.o_req_ready), 32'd0);
      chk($sformatf("halt%0d_stop_clk", k), 32'(bus.o_stop_write_clk), 32'd0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 'hD0002, 1, 0, 0);
    chk_beat("halt_resume", 'h09, 'hD0001);
    chk("halt_resume_fill_ready", 32'(bus.o_fill_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 1, 'hD0003, 1, 0, 0);
    chk_beat("halt_b2", 'h0A, 'hD0002);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk_beat("halt_b3", 'h0B, 'hD0003);
    tick();
    @(negedge clk);
    chk("halt_done", 32'(bus.o_done), 32'd1);
    tick();
    @(negedge clk);
    chk("halt_done_once", 32'(bus.o_done), 32'd0);
    chk("halt_idle_busy", 32'(bus.o_busy), 32'd0);

    // reset in the middle of a fill
    set_in(1, 'h07, 'h1, 3, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 'hE0000, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 'hE0001, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    chk("mid_pre_w_valid", 32'(bus.o_w_valid), 32'd1);
    tick();
    set_in(1, 'h07, 'h1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("mid_w_valid", 32'(bus.o_w_valid), 32'd0);
    chk("mid_stop_clk", 32'(bus.o_stop_write_clk), 32'd1);
    chk("mid_req_ready", 32'(bus.o_req_ready), 32'd1);
    chk("mid_busy", 32'(bus.o_busy), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 0, 0, (k < 4) ? 1 : 0, 'hF0000 + k, 1, 0, 0);
      if (k > 0) chk_beat($sformatf("mid_new%0d", k - 1), 'h1C + k - 1, 'hF0000 + k - 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("mid_new_done", 32'(bus.o_done), 32'd1);
    tick();

    // idle stretch keeps the write clock gated
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_stop_clk", k), 32'(bus.o_stop_write_clk), 32'd1);
      chk($sformatf("idle%0d_busy", k), 32'(bus.o_busy), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_array_refill_writer.md
Name: data_array_refill_writer

Overview:
Line-fill engine that drives the write port of the instruction-cache data arrays after a miss. It accepts one refill command (set index plus one-hot target way), then takes WORDS_PER_LINE words from the memory-side fill stream. Each word becomes one registered write beat: address, data, valid and way mask. It also drives the write-clock gate request, so the data-array write clock runs only while a fill is in progress.

Parameters:
ADDR_WIDTH, 8, data-array word address width ({set, offset}).
WORD_WIDTH, 20, instruction word width.
NUM_BLOCKS, 4, number of ways; one SRAM per way.
WORDS_PER_LINE, 4, words per cache line; must be a power of 2, >=2.

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
i_halt_all  in  1  freezes all state; no handshakes complete
i_req_valid  in  1  refill command valid
i_req_set  in  ADDR_WIDTH-log2(WORDS_PER_LINE)  set index
i_req_way  in  NUM_BLOCKS  one-hot target way
i_req_first_word  in  log2(WORDS_PER_LINE)  offset of the first word delivered
o_req_ready  out  1  command accepted when valid&ready
i_fill_data  in  WORD_WIDTH  refill word
i_fill_valid  in  1  refill word valid
o_fill_ready  out  1  refill word accepted when valid&ready
o_w_addr  out  ADDR_WIDTH  {set, offset}
o_w_data  out  WORD_WIDTH  write data
o_w_valid  out  1  write beat valid
o_w_mask  out  NUM_BLOCKS  way select
i_w_ready  in  1  data arrays ready; beat retires when o_w_valid&i_w_ready
o_stop_write_clk  out  1  request to gate the write clock
o_busy  out  1  high in FILL and DONE
o_done  out  1  one-cycle pulse when the line is fully written

Behaviour:
- Interface: one clock `clk`; reset `srst` is synchronous and active-high.
- Reset values: state IDLE, o_w_valid=0, o_w_addr/o_w_data/o_w_mask=0, o_done=0, o_busy=0, o_stop_write_clk=1.
- Reset mid-fill: returns to IDLE on the next edge, clears counters, drops any pending beat. No further writes are issued.
- States:
  - IDLE: o_req_ready=~i_halt_all. On acceptance, capture set, way and start offset; clear the accepted and written counters; go to FILL.
  - FILL: o_fill_ready = ~i_halt_all & (accepted<WORDS_PER_LINE) & (~o_w_valid | i_w_ready).
  - FILL, word accepted: at the next edge o_w_valid=1, o_w_data=word, o_w_addr={set, offset}, o_w_mask=captured way. Then offset increments modulo WORDS_PER_LINE (wraps) and accepted increments.
  - FILL, beat retired: written increments. If the retiring beat is the last (written reaches WORDS_PER_LINE) with no new word accepted, go to DONE with o_w_valid=0.
  - Same-cycle retire and accept: o_w_valid stays 1 and the registers load the new word. Back-to-back throughput is 1 word/cycle.
  - DONE: o_done=1 for exactly one cycle, then IDLE. A request offered in DONE is not accepted (o_req_ready=0).
- Latency: word accepted at cycle N -> write beat visible at N+1. Minimum command-to-o_done time is WORDS_PER_LINE+2 cycles.
- o_stop_write_clk = ~(state==FILL), decoded directly from the state register.
- i_halt_all: no state, counter or output register changes; o_req_ready=o_fill_ready=0. o_w_valid holds its value. Beats are not counted as retired while halted, even if i_w_ready=1.
- Width rules: counters are log2(WORDS_PER_LINE)+1 bits; offset arithmetic is log2(WORDS_PER_LINE) bits, wrap-around by truncation.
- Non-one-hot i_req_way is not checked. The captured mask drives o_w_mask verbatim (zero mask: beats are issued but no SRAM is enabled).

Optional Feature:
REFILL_WRAP_FIRST_EN
- Defined: the start offset is i_req_first_word and the fill wraps (critical-word-first order).
- Undefined: the start offset is always 0 and i_req_first_word is ignored. The port stays present.

Decomposition:
- Shared header/package icache_defs:
  - ADDR_WIDTH, WORD_WIDTH, NUM_BLOCKS, WORDS_PER_LINE.
  - Derived OFFSET_WIDTH=log2(WORDS_PER_LINE) and SET_WIDTH=ADDR_WIDTH-OFFSET_WIDTH.
  - Refill state encodings IDLE/FILL/DONE.
- One natural sub-module: refill_offset_counter, a wrapping offset plus accepted-count register with load, increment and halt enable.

Test Plan:
- Clean fill: req set=0x05, way=4'b0010, first=0; words 0xA0000..0xA0003 on consecutive cycles; i_w_ready=1 -> o_w_addr 0x14,0x15,0x16,0x17 on consecutive cycles; mask 0010; o_done pulses once, 6 cycles after the req handshake.
- Wrap (REFILL_WRAP_FIRST_EN): set=0x3F, first=2 -> o_w_addr 0xFE,0xFF,0xFC,0xFD. With the macro undefined, the same stimulus gives 0xFC..0xFF.
- Backpressure: i_w_ready=0 for 3 cycles during beat 2 -> o_w_valid/addr/data held; o_fill_ready=0; no word lost or duplicated.
- Halt: i_halt_all=1 for 4 cycles mid-fill with i_fill_valid=1 -> no handshakes, outputs frozen; the fill resumes and completes with the correct 4 beats.
- Reset mid-fill: srst after 2 beats -> next cycle o_w_valid=0, o_stop_write_clk=1, o_req_ready=1. A new request then writes from offset 0 (first=0).
- Gating/idle: no request for 10 cycles -> o_stop_write_clk=1, o_busy=0. A request in the DONE cycle is held off until IDLE.
